product_accumulator: RTL and testbench

- Downstream consumer of the 4x4 array multiplier's 8-bit product.
- Accumulates a fixed batch of N_TERMS products into an ACC_W-bit sum.
- Tracks overflow during accumulation.
- Streams the finished sum out byte-serially, LSB first, over a valid/ready handshake so it fits the 8-bit tile output pins.

---
 rtl/product_accumulator.sv | 121 ++++++++++++
 tb/tb_product_accumulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Accumulates N_TERMS unsigned 8-bit products into an ACC_W-bit sum, then streams the
// sum out LSB byte first over valid/ready. Define PRODUCT_ACC_SATURATE_EN to clamp instead of wrap.
module product_accumulator #(
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] prod_in,
    input  logic       prod_valid,
    output logic       prod_ready,
    output logic [7:0] res_data,
    output logic       res_valid,
    output logic       res_last,
    input  logic       res_ready,
    output logic       overflow,
    output logic       busy
);
    localparam int NB    = ACC_W / 8;
    localparam int BIW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);
    localparam logic [BIW-1:0]   LAST_BYTE = BIW'(NB - 1);

    typedef enum logic {ACC, OUT} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIW-1:0]     idx_q, idx_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W:0]     sum_w;
    logic               carry;
    logic [ACC_W-1:0]   add_val;

    assign sum_w = {1'b0, acc_q} + (ACC_W+1)'(prod_in);
    assign carry = sum_w[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
    // Once clamped, any further addition carries again, so acc stays pinned at all ones.
    assign add_val = carry ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
    assign add_val = sum_w[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACC: begin
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (prod_valid) begin
                    ovf_d = ovf_q | carry;
                    if (cnt_q == LAST_TERM) begin
                        res_d   = add_val;
                        acc_d   = '0;
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = OUT;
                    end else begin
                        acc_d = add_val;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                // clear aborts the stream; a coincident res_ready does not count a byte.
                if (clear) begin
                    state_d = ACC;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                end else if (res_ready) begin
                    if (idx_q == LAST_BYTE) begin
                        state_d = ACC;
                        idx_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prod_ready = (state_q == ACC);
    assign res_valid  = (state_q == OUT);
    assign res_data   = (state_q == OUT) ? res_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign res_last   = (state_q == OUT) && (idx_q == LAST_BYTE);
    assign overflow   = ovf_q;
    assign busy       = (state_q == OUT) || (cnt_q != '0);

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: default instance driven through a byte scoreboard,
// plus an ACC_W=8/N_TERMS=2 instance for the overflow/saturation case.
module tb_product_accumulator;
    logic       clk, rst_n, clear;
    logic [7:0] prod_in;
    logic       prod_valid, prod_ready;
    logic [7:0] res_data;
    logic       res_valid, res_last, res_ready, overflow, busy;

    logic [7:0] prod_in8, res_data8;
    logic       prod_valid8, prod_ready8, res_valid8, res_last8, res_ready8, overflow8, busy8;

    product_accumulator #(.ACC_W(16), .N_TERMS(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
        .res_ready(res_ready), .overflow(overflow), .busy(busy)
    );

    product_accumulator #(.ACC_W(8), .N_TERMS(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .prod_in(prod_in8), .prod_valid(prod_valid8), .prod_ready(prod_ready8),
        .res_data(res_data8), .res_valid(res_valid8), .res_last(res_last8),
        .res_ready(res_ready8), .overflow(overflow8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] data; logic last; logic ovf; } exp_t;
    typedef struct packed { logic [3:0][7:0] p; logic [15:0] sum; } vec_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   pr_low  = 0;
    bit   acc_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observes the handshakes that will complete on the coming rising edge.
    task automatic mon();
        exp_t e;
        if (!rst_n) return;
        if (!prod_ready) pr_low++;
        if (prod_valid && prod_ready && !clear) begin
            acc_seen = 1'b1;
            n_acc++;
            chk("no_accept_while_res_valid", {31'd0, res_valid}, 32'd0);
        end
        if (res_valid && res_ready && !clear) begin
            if (q.size() == 0) begin
                chk("unexpected_byte", {24'd0, res_data}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("res_data", {24'd0, res_data}, {24'd0, e.data});
                chk("res_last", {31'd0, res_last}, {31'd0, e.last});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            end
        end
    endtask

    task automatic step();
        mon();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] p);
        int t;
        prod_in    = p;
        prod_valid = 1'b1;
        acc_seen   = 1'b0;
        for (t = 0; t < 100 && !acc_seen; t++) step();
        if (!acc_seen) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic push16(input logic [15:0] s);
        q.push_back('{data: s[7:0],  last: 1'b0, ovf: 1'b0});
        q.push_back('{data: s[15:8], last: 1'b1, ovf: 1'b0});
    endtask

    task automatic drain(input int keep);
        int t;
        for (t = 0; t < 200 && q.size() > keep; t++) step();
        if (q.size() > keep) chk("drain_timeout", q.size(), keep);
    endtask

    vec_t vt[4];

    initial begin
        vt[0] = '{p: {8'hE1, 8'hE1, 8'hE1, 8'hE1}, sum: 16'h0384};
        vt[1] = '{p: {8'h04, 8'h03, 8'h02, 8'h01}, sum: 16'h000A};
        vt[2] = '{p: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, sum: 16'h03FC};
        vt[3] = '{p: {8'h00, 8'h00, 8'h00, 8'h00}, sum: 16'h0000};

        rst_n = 1'b0; clear = 1'b0; prod_in = '0; prod_valid = 1'b0; res_ready = 1'b1;
        prod_in8 = '0; prod_valid8 = 1'b0; res_ready8 = 1'b0;
        @(negedge clk);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data",  {24'd0, res_data}, 32'd0);
        chk("rst_res_last",  {31'd0, res_last}, 32'd0);
        chk("rst_overflow",  {31'd0, overflow}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_prod_ready",{31'd0, prod_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven batches, continuous valid, res_ready=1
        for (int v = 0; v < 4; v++) begin
            pr_low = 0;
            push16(vt[v].sum);
            for (int k = 0; k < 4; k++) send(vt[v].p[k]);
            prod_valid = 1'b0;
            drain(0);
            chk("prod_ready_low_cycles", pr_low, 2);
            chk("ready_after_batch", {31'd0, prod_ready}, 32'd1);
        end

        // Backpressure: res_ready low for 3 cycles while a product is offered
        res_ready = 1'b0;
        push16(16'h0384);
        for (int k = 0; k < 4; k++) send(8'hE1);
        prod_in = 8'h55;
        for (int k = 0; k < 3; k++) begin
            chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_res_data", {24'd0, res_data}, 32'h84);
            chk("stall_res_last", {31'd0, res_last}, 32'd0);
            chk("stall_prod_ready", {31'd0, prod_ready}, 32'd0);
            step();
        end
        prod_valid = 1'b0;
        res_ready  = 1'b1;
        drain(0);

        // Clear in ACC drops the coincident product
        send(8'h10);
        send(8'h10);
        prod_valid = 1'b0;
        chk("busy_mid_batch", {31'd0, busy}, 32'd1);
        prod_in = 8'h10; prod_valid = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; prod_valid = 1'b0;
        chk("busy_after_clear", {31'd0, busy}, 32'd0);
        push16(16'h0004);
        for (int k = 0; k < 4; k++) send(8'h01);
        prod_valid = 1'b0;
        drain(0);

        // Clear in OUT aborts output; coincident res_ready not counted
        push16(16'h0004);
        for (int k = 0; k < 4; k++) send(8'h01);
        prod_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        q.delete();
        chk("out_clear_res_valid", {31'd0, res_valid}, 32'd0);
        chk("out_clear_prod_ready", {31'd0, prod_ready}, 32'd1);
        chk("out_clear_busy", {31'd0, busy}, 32'd0);

        // Async reset during OUT after the first byte
        push16(16'h0100);
        for (int k = 0; k < 4; k++) send(8'h40);
        prod_valid = 1'b0;
        drain(1);
        res_ready = 1'b0;
        chk("pre_reset_res_valid", {31'd0, res_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("async_rst_prod_ready", {31'd0, prod_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        push16(16'h0008);
        for (int k = 0; k < 4; k++) send(8'h02);
        prod_valid = 1'b0;
        drain(0);

        // 12 products with valid held high: three back-to-back batches
        n_acc = 0;
        for (int b = 0; b < 3; b++) push16(16'h0004);
        prod_in = 8'h01; prod_valid = 1'b1;
        for (int t = 0; t < 200 && n_acc < 12; t++) step();
        prod_valid = 1'b0;
        chk("stream_accepts", n_acc, 12);
        drain(0);

        // ACC_W=8, N_TERMS=2: wrap or saturate, overflow clears after the byte
        prod_in8 = 8'hE1; prod_valid8 = 1'b1;
        step();
        chk("u8_busy_mid", {31'd0, busy8}, 32'd1);
        step();
        prod_valid8 = 1'b0;
        chk("u8_res_valid", {31'd0, res_valid8}, 32'd1);
`ifdef PRODUCT_ACC_SATURATE_EN
        chk("u8_res_data", {24'd0, res_data8}, 32'hFF);
`else
        chk("u8_res_data", {24'd0, res_data8}, 32'hC2);
`endif
        chk("u8_res_last", {31'd0, res_last8}, 32'd1);
        chk("u8_overflow", {31'd0, overflow8}, 32'd1);
        chk("u8_prod_ready", {31'd0, prod_ready8}, 32'd0);
        res_ready8 = 1'b1;
        step();
        res_ready8 = 1'b0;
        chk("u8_overflow_cleared", {31'd0, overflow8}, 32'd0);
        chk("u8_res_valid_done", {31'd0, res_valid8}, 32'd0);
        chk("u8_prod_ready_back", {31'd0, prod_ready8}, 32'd1);

        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
